// File: rtl/multicycle_control_unit_if.sv
// Control/status bundle between the multicycle control unit and its datapath.
// master = control unit side (reads status, drives controls)
// slave  = datapath side (drives status, reads controls)
// Optional: CU_INSTR_COUNT_EN adds the retired-instruction counter output.
interface multicycle_control_unit_if
`ifdef CU_INSTR_COUNT_EN
    #(parameter int COUNT_W = 16)
`endif
    ;
    logic [3:0] IrToCU;
    logic [4:0] DiToCU;
    logic [2:0] CznToCU;

    logic       pcInc;
    logic       pcLoadEn;
    logic       diLoadEn;
    logic       irWriteEn;
    logic       trWriteEn;
    logic       accumulatorWriteEn;
    logic       aRegWriteEn;
    logic       bRegWriteEn;
    logic       aluResWriteEn;
    logic       ldCZN;
    logic       memoryReadEn;
    logic       memoryWriteEn;
    logic       reg1Or2;
    logic       PcOrTR;
    logic       regOrMem;
    logic       RegBOr0;
    logic       RegAOr0;
    logic [1:0] aluOpControl;
`ifdef CU_INSTR_COUNT_EN
    logic [COUNT_W-1:0] instrCount;
`endif

    modport master (
        input  IrToCU, DiToCU, CznToCU,
`ifdef CU_INSTR_COUNT_EN
        output instrCount,
`endif
        output pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn,
        output accumulatorWriteEn, aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN,
        output memoryReadEn, memoryWriteEn,
        output reg1Or2, PcOrTR, regOrMem, RegBOr0, RegAOr0, aluOpControl
    );

    modport slave (
        output IrToCU, DiToCU, CznToCU,
`ifdef CU_INSTR_COUNT_EN
        input  instrCount,
`endif
        input  pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn,
        input  accumulatorWriteEn, aRegWriteEn, bRegWriteEn, aluResWriteEn, ldCZN,
        input  memoryReadEn, memoryWriteEn,
        input  reg1Or2, PcOrTR, regOrMem, RegBOr0, RegAOr0, aluOpControl
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle CPU datapath: fetch, decode, execute,
// one instruction at a time (3 to 6 cycles each).
// Optional: define CU_INSTR_COUNT_EN to add the retired-instruction counter
// (instrCount, COUNT_W bits, wraps).
//
// state   | meaning
// --------+------------------------------------------------------------
// BOOT    | post-reset idle cycle, all controls low
// FETCH   | IR <- mem[PC], PC++
// DECODE  | DI <- IR[4:0]; branch on register vs memory instruction
// FETCH2  | TR <- mem[PC] (second byte), PC++; dispatch on op / Z flag
// JUMP    | PC <- target (JMP, taken JZ)
// LD_MEM  | B <- mem[TR]
// LD_ALU  | ALU result <- 0 + B (flags untouched)
// LD_WB   | R[DI[1:0]] <- ALU result
// ST_A    | A <- R[DI[1:0]]
// ST_ALU  | ALU result <- A + 0
// ST_WR   | mem[TR] <- ALU result
// REG_A   | A <- R[DI[1:0]]
// REG_B   | B <- R[DI[3:2]]
// REG_ALU | ALU result <- A op B, flags loaded
// REG_WB  | R[DI[1:0]] <- ALU result
module multicycle_control_unit #(
    parameter int COUNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_control_unit_if.master bus
);
    localparam logic [3:0] BOOT    = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] DECODE  = 4'd2;
    localparam logic [3:0] FETCH2  = 4'd3;
    localparam logic [3:0] JUMP    = 4'd4;
    localparam logic [3:0] LD_MEM  = 4'd5;
    localparam logic [3:0] LD_ALU  = 4'd6;
    localparam logic [3:0] LD_WB   = 4'd7;
    localparam logic [3:0] ST_A    = 4'd8;
    localparam logic [3:0] ST_ALU  = 4'd9;
    localparam logic [3:0] ST_WR   = 4'd10;
    localparam logic [3:0] REG_A   = 4'd11;
    localparam logic [3:0] REG_B   = 4'd12;
    localparam logic [3:0] REG_ALU = 4'd13;
    localparam logic [3:0] REG_WB  = 4'd14;

    if (COUNT_W < 1) begin : g_count_w_check
        $error("COUNT_W must be at least 1");
    end

    logic [3:0] state;
    logic [3:0] state_next;

    // DI and the C/N flags are consumed by the datapath, not by sequencing.
    logic unused_status;
    assign unused_status = ^{bus.DiToCU, bus.IrToCU[0], bus.CznToCU[2], bus.CznToCU[0]};

    // State register; reset parks in BOOT so every control drops at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= BOOT;
        else      state <= state_next;
    end

    // Next-state selection; unused encodings recover through BOOT.
    always_comb begin
        state_next = BOOT;
        case (state)
            BOOT:    state_next = FETCH;
            FETCH:   state_next = DECODE;
            DECODE:  state_next = bus.IrToCU[3] ? REG_A : FETCH2;
            FETCH2: begin
                case (bus.IrToCU[2:1])
                    2'b00:   state_next = LD_MEM;
                    2'b01:   state_next = ST_A;
                    2'b10:   state_next = JUMP;
                    default: state_next = bus.CznToCU[1] ? JUMP : FETCH;
                endcase
            end
            JUMP:    state_next = FETCH;
            LD_MEM:  state_next = LD_ALU;
            LD_ALU:  state_next = LD_WB;
            LD_WB:   state_next = FETCH;
            ST_A:    state_next = ST_ALU;
            ST_ALU:  state_next = ST_WR;
            ST_WR:   state_next = FETCH;
            REG_A:   state_next = REG_B;
            REG_B:   state_next = REG_ALU;
            REG_ALU: state_next = REG_WB;
            REG_WB:  state_next = FETCH;
            default: state_next = BOOT;
        endcase
    end

    // Control decode from the state register only (Moore outputs).
    always_comb begin
        bus.pcInc              = 1'b0;
        bus.pcLoadEn           = 1'b0;
        bus.diLoadEn           = 1'b0;
        bus.irWriteEn          = 1'b0;
        bus.trWriteEn          = 1'b0;
        bus.accumulatorWriteEn = 1'b0;
        bus.aRegWriteEn        = 1'b0;
        bus.bRegWriteEn        = 1'b0;
        bus.aluResWriteEn      = 1'b0;
        bus.ldCZN              = 1'b0;
        bus.memoryReadEn       = 1'b0;
        bus.memoryWriteEn      = 1'b0;
        bus.reg1Or2            = 1'b0;
        bus.PcOrTR             = 1'b0;
        bus.regOrMem           = 1'b0;
        bus.RegBOr0            = 1'b0;
        bus.RegAOr0            = 1'b0;
        bus.aluOpControl       = 2'b00;
        case (state)
            FETCH: begin
                bus.PcOrTR       = 1'b1;
                bus.memoryReadEn = 1'b1;
                bus.irWriteEn    = 1'b1;
                bus.pcInc        = 1'b1;
            end
            DECODE: bus.diLoadEn = 1'b1;
            FETCH2: begin
                bus.PcOrTR       = 1'b1;
                bus.memoryReadEn = 1'b1;
                bus.trWriteEn    = 1'b1;
                bus.pcInc        = 1'b1;
            end
            JUMP: bus.pcLoadEn = 1'b1;
            LD_MEM: begin
                bus.memoryReadEn = 1'b1;
                bus.bRegWriteEn  = 1'b1;
            end
            LD_ALU: begin
                bus.RegAOr0       = 1'b1;
                bus.aluResWriteEn = 1'b1;
            end
            LD_WB:  bus.accumulatorWriteEn = 1'b1;
            ST_A:   bus.aRegWriteEn = 1'b1;
            ST_ALU: begin
                bus.RegBOr0       = 1'b1;
                bus.aluResWriteEn = 1'b1;
            end
            ST_WR:  bus.memoryWriteEn = 1'b1;
            REG_A:  bus.aRegWriteEn = 1'b1;
            REG_B: begin
                bus.reg1Or2     = 1'b1;
                bus.regOrMem    = 1'b1;
                bus.bRegWriteEn = 1'b1;
            end
            REG_ALU: begin
                bus.aluOpControl  = bus.IrToCU[2:1];
                bus.aluResWriteEn = 1'b1;
                bus.ldCZN         = 1'b1;
            end
            REG_WB: bus.accumulatorWriteEn = 1'b1;
            default: ;
        endcase
    end

`ifdef CU_INSTR_COUNT_EN
    logic [COUNT_W-1:0] instr_count;

    // Count instruction completions (any entry to FETCH except from BOOT).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instr_count <= '0;
        else if (state_next == FETCH && state != BOOT)
            instr_count <= instr_count + 1'b1;
    end

    assign bus.instrCount = instr_count;
`endif
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Control outputs are packed into
// one word and compared against hand-written per-state expectations.
module tb_multicycle_control_unit;
    localparam int COUNT_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total  = 0;
`ifdef CU_INSTR_COUNT_EN
    logic [COUNT_W-1:0] exp_count;
    multicycle_control_unit_if #(.COUNT_W(COUNT_W)) bus ();
`else
    multicycle_control_unit_if bus ();
`endif

    multicycle_control_unit #(.COUNT_W(COUNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    localparam logic [18:0] E_PCINC = 19'd1 << 18;
    localparam logic [18:0] E_PCLD  = 19'd1 << 17;
    localparam logic [18:0] E_DILD  = 19'd1 << 16;
    localparam logic [18:0] E_IRWE  = 19'd1 << 15;
    localparam logic [18:0] E_TRWE  = 19'd1 << 14;
    localparam logic [18:0] E_ACCWE = 19'd1 << 13;
    localparam logic [18:0] E_AWE   = 19'd1 << 12;
    localparam logic [18:0] E_BWE   = 19'd1 << 11;
    localparam logic [18:0] E_ALUWE = 19'd1 << 10;
    localparam logic [18:0] E_LDCZN = 19'd1 << 9;
    localparam logic [18:0] E_MRD   = 19'd1 << 8;
    localparam logic [18:0] E_MWR   = 19'd1 << 7;
    localparam logic [18:0] E_R12   = 19'd1 << 6;
    localparam logic [18:0] E_PCTR  = 19'd1 << 5;
    localparam logic [18:0] E_RORM  = 19'd1 << 4;
    localparam logic [18:0] E_BOR0  = 19'd1 << 3;
    localparam logic [18:0] E_AOR0  = 19'd1 << 2;

    localparam logic [18:0] W_ZERO    = 19'd0;
    localparam logic [18:0] W_FETCH   = E_PCTR | E_MRD | E_IRWE | E_PCINC;
    localparam logic [18:0] W_DECODE  = E_DILD;
    localparam logic [18:0] W_FETCH2  = E_PCTR | E_MRD | E_TRWE | E_PCINC;
    localparam logic [18:0] W_JUMP    = E_PCLD;
    localparam logic [18:0] W_LD_MEM  = E_MRD | E_BWE;
    localparam logic [18:0] W_LD_ALU  = E_AOR0 | E_ALUWE;
    localparam logic [18:0] W_LD_WB   = E_ACCWE;
    localparam logic [18:0] W_ST_A    = E_AWE;
    localparam logic [18:0] W_ST_ALU  = E_BOR0 | E_ALUWE;
    localparam logic [18:0] W_ST_WR   = E_MWR;
    localparam logic [18:0] W_REG_A   = E_AWE;
    localparam logic [18:0] W_REG_B   = E_R12 | E_RORM | E_BWE;
    localparam logic [18:0] W_REG_ALU = E_ALUWE | E_LDCZN;
    localparam logic [18:0] W_REG_WB  = E_ACCWE;

    logic [18:0] ctrl;
    assign ctrl = {bus.pcInc, bus.pcLoadEn, bus.diLoadEn, bus.irWriteEn, bus.trWriteEn,
                   bus.accumulatorWriteEn, bus.aRegWriteEn, bus.bRegWriteEn,
                   bus.aluResWriteEn, bus.ldCZN, bus.memoryReadEn, bus.memoryWriteEn,
                   bus.reg1Or2, bus.PcOrTR, bus.regOrMem, bus.RegBOr0, bus.RegAOr0,
                   bus.aluOpControl};

    task automatic test_reset;
        rst = 1'b0;
        bus.IrToCU = 4'b0000;
        bus.DiToCU = 5'b00000;
        bus.CznToCU = 3'b000;
        repeat (3) @(negedge clk);
        total++;
        if (ctrl !== W_ZERO) $display("FAIL reset_hold: ctrl=%b expected %b", ctrl, W_ZERO);
        else passed++;
        rst = 1'b1;
        #1;
        total++;
        if (ctrl !== W_ZERO) $display("FAIL reset_boot: ctrl=%b expected %b", ctrl, W_ZERO);
        else passed++;
        @(negedge clk);
        total++;
        if (ctrl !== W_FETCH) $display("FAIL reset_fetch: ctrl=%b expected %b", ctrl, W_FETCH);
        else passed++;
`ifdef CU_INSTR_COUNT_EN
        exp_count = '0;
        total++;
        if (bus.instrCount !== exp_count)
            $display("FAIL reset_count: instrCount=%0d expected %0d", bus.instrCount, exp_count);
        else passed++;
`endif
    endtask

    task automatic test_reg_sub;
        logic [18:0] seq [7];
        seq = '{W_FETCH, W_DECODE, W_REG_A, W_REG_B, W_REG_ALU | 19'b10, W_REG_WB, W_FETCH};
        bus.IrToCU = 4'b1100;
        bus.DiToCU = 5'b00110;
        bus.CznToCU = 3'b000;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ctrl !== seq[i]) $display("FAIL reg_sub step %0d: ctrl=%b expected %b", i, ctrl, seq[i]);
            else passed++;
            if (i < 6) @(negedge clk);
        end
`ifdef CU_INSTR_COUNT_EN
        exp_count = exp_count + 1'b1;
        total++;
        if (bus.instrCount !== exp_count)
            $display("FAIL reg_sub_count: instrCount=%0d expected %0d", bus.instrCount, exp_count);
        else passed++;
`endif
    endtask

    task automatic test_reg_ops;
        logic [3:0]  irs [3];
        logic [18:0] alu_w [3];
        irs   = '{4'b1000, 4'b1010, 4'b1110};
        alu_w = '{W_REG_ALU | 19'b00, W_REG_ALU | 19'b01, W_REG_ALU | 19'b11};
        for (int k = 0; k < 3; k++) begin
            bus.IrToCU = irs[k];
            bus.DiToCU = 5'b01001;
            repeat (4) @(negedge clk);
            total++;
            if (ctrl !== alu_w[k]) $display("FAIL reg_op %0d alu: ctrl=%b expected %b", k, ctrl, alu_w[k]);
            else passed++;
            repeat (2) @(negedge clk);
            total++;
            if (ctrl !== W_FETCH) $display("FAIL reg_op %0d end: ctrl=%b expected %b", k, ctrl, W_FETCH);
            else passed++;
`ifdef CU_INSTR_COUNT_EN
            exp_count = exp_count + 1'b1;
`endif
        end
    endtask

    task automatic test_lda;
        logic [18:0] seq [7];
        seq = '{W_FETCH, W_DECODE, W_FETCH2, W_LD_MEM, W_LD_ALU, W_LD_WB, W_FETCH};
        bus.IrToCU = 4'b0000;
        bus.CznToCU = 3'b111;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ctrl !== seq[i]) $display("FAIL lda step %0d: ctrl=%b expected %b", i, ctrl, seq[i]);
            else passed++;
            if (i < 6) @(negedge clk);
        end
`ifdef CU_INSTR_COUNT_EN
        exp_count = exp_count + 1'b1;
`endif
    endtask

    task automatic test_sta;
        logic [18:0] seq [7];
        seq = '{W_FETCH, W_DECODE, W_FETCH2, W_ST_A, W_ST_ALU, W_ST_WR, W_FETCH};
        bus.IrToCU = 4'b0010;
        bus.CznToCU = 3'b000;
        for (int i = 0; i < 7; i++) begin
            total++;
            if (ctrl !== seq[i]) $display("FAIL sta step %0d: ctrl=%b expected %b", i, ctrl, seq[i]);
            else passed++;
            if (i < 6) @(negedge clk);
        end
`ifdef CU_INSTR_COUNT_EN
        exp_count = exp_count + 1'b1;
        total++;
        if (bus.instrCount !== exp_count)
            $display("FAIL sta_count: instrCount=%0d expected %0d", bus.instrCount, exp_count);
        else passed++;
`endif
    endtask

    task automatic test_jz;
        logic [18:0] taken [5];
        logic [18:0] not_taken [4];
        taken     = '{W_FETCH, W_DECODE, W_FETCH2, W_JUMP, W_FETCH};
        not_taken = '{W_FETCH, W_DECODE, W_FETCH2, W_FETCH};
        bus.IrToCU = 4'b0110;
        bus.CznToCU = 3'b010;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ctrl !== taken[i]) $display("FAIL jz_taken step %0d: ctrl=%b expected %b", i, ctrl, taken[i]);
            else passed++;
            if (i < 4) @(negedge clk);
        end
        bus.CznToCU = 3'b000;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ctrl !== not_taken[i]) $display("FAIL jz_not_taken step %0d: ctrl=%b expected %b", i, ctrl, not_taken[i]);
            else passed++;
            if (i < 3) @(negedge clk);
        end
`ifdef CU_INSTR_COUNT_EN
        exp_count = exp_count + 2'd2;
        total++;
        if (bus.instrCount !== exp_count)
            $display("FAIL jz_count: instrCount=%0d expected %0d", bus.instrCount, exp_count);
        else passed++;
`endif
    endtask

    task automatic test_mid_reset;
        bus.IrToCU = 4'b0000;
        repeat (4) @(negedge clk);
        total++;
        if (ctrl !== W_LD_ALU) $display("FAIL mid_reset_pre: ctrl=%b expected %b", ctrl, W_LD_ALU);
        else passed++;
        #2;
        rst = 1'b0;
        #1;
        total++;
        if (ctrl !== W_ZERO) $display("FAIL mid_reset_async: ctrl=%b expected %b", ctrl, W_ZERO);
        else passed++;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (ctrl !== W_ZERO) $display("FAIL mid_reset_boot: ctrl=%b expected %b", ctrl, W_ZERO);
        else passed++;
        @(negedge clk);
        total++;
        if (ctrl !== W_FETCH) $display("FAIL mid_reset_fetch: ctrl=%b expected %b", ctrl, W_FETCH);
        else passed++;
`ifdef CU_INSTR_COUNT_EN
        exp_count = '0;
        total++;
        if (bus.instrCount !== exp_count)
            $display("FAIL mid_reset_count: instrCount=%0d expected %0d", bus.instrCount, exp_count);
        else passed++;
`endif
    endtask

`ifdef CU_INSTR_COUNT_EN
    task automatic test_counter_wrap;
        logic [COUNT_W-1:0] want [3];
        want = '{4'd15, 4'd0, 4'd1};
        bus.IrToCU = 4'b0100;
        for (int n = 1; n <= 17; n++) begin
            repeat (4) @(negedge clk);
            if (n >= 15) begin
                total++;
                if (bus.instrCount !== want[n-15])
                    $display("FAIL count_wrap after %0d jmps: instrCount=%0d expected %0d", n, bus.instrCount, want[n-15]);
                else passed++;
            end
        end
        total++;
        if (ctrl !== W_FETCH) $display("FAIL count_wrap_end: ctrl=%b expected %b", ctrl, W_FETCH);
        else passed++;
    endtask
`endif

    initial begin
        rst = 1'b0;
        test_reset();
        test_reg_sub();
        test_reg_ops();
        test_lda();
        test_sta();
        test_jz();
        test_mid_reset();
`ifdef CU_INSTR_COUNT_EN
        test_counter_wrap();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
